parking_gate_arbiter: RTL

Shares the lot's single occupancy-booking unit between two entry gates and two exit gates. Each gate raises a held request; the block picks one gate round-robin, checks capacity for that car class, updates the university/free occupancy counters, and either opens that gate's barrier for a fixed time or denies it. It sits between the gate sensors and the hour-of-day timekeeper, and it is the only writer of the occupancy counts.

---
 rtl/parking_gate_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin shared occupancy booking for two entry and two exit gates
module parking_gate_arbiter #(
  parameter int UNI_SPACES          = 500,
  parameter int FREE_SPACES_MORNING = 200,
  parameter int TOTAL_SPACES        = 700,
  parameter int MORNING_START       = 8,
  parameter int MORNING_END         = 13,
  parameter int GATE_CYCLES         = 16,
  parameter int CNT_W               = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       hour,
  input  logic [3:0]       req,
  input  logic [3:0]       req_uni,
  output logic [3:0]       grant,
  output logic [3:0]       deny,
  output logic [3:0]       gate_open,
  output logic [CNT_W-1:0] car_parked_u,
  output logic [CNT_W-1:0] car_parked_f,
  output logic [CNT_W-1:0] vacant_u,
  output logic [CNT_W-1:0] vacant_f,
  output logic             full_u,
  output logic             full_f,
  output logic             busy,
  output logic             err
);
  localparam int GW = $clog2(GATE_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, DECIDE, OPEN, WAIT_DROP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic pick_v, uni_q, uni_d, err_q, err_d, morning, is_exit, accept;
  logic [3:0] grant_q, grant_d, deny_q, deny_d, win_oh;
  logic [CNT_W-1:0] cnt_u_q, cnt_u_d, cnt_f_q, cnt_f_d, cap_f;
  logic [GW-1:0] tmr_q, tmr_d;
  always_comb begin
    pick = ptr_q;
    pick_v = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (req[ptr_q + 2'(i)]) begin
        pick = ptr_q + 2'(i);
        pick_v = 1'b1;
      end
  end
  assign morning  = hour >= 5'(MORNING_START) && hour < 5'(MORNING_END);
  assign cap_f    = morning ? CNT_W'(FREE_SPACES_MORNING) : CNT_W'(TOTAL_SPACES) - cnt_u_q;
  assign vacant_u = CNT_W'(UNI_SPACES) - cnt_u_q;
  assign vacant_f = cnt_f_q >= cap_f ? '0 : cap_f - cnt_f_q;
  assign full_u   = vacant_u == '0;
  assign full_f   = vacant_f == '0;
  assign is_exit  = win_q[1];
  assign win_oh   = 4'b0001 << win_q;
  assign accept   = uni_q ? (is_exit ? cnt_u_q != '0 : cnt_u_q < CNT_W'(UNI_SPACES))
                          : (is_exit ? cnt_f_q != '0 : cnt_f_q < cap_f);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    uni_d = uni_q;
    cnt_u_d = cnt_u_q;
    cnt_f_d = cnt_f_q;
    tmr_d = tmr_q;
    grant_d = '0;
    deny_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (pick_v) begin
        win_d = pick;
        uni_d = req_uni[pick];
        ptr_d = pick + 2'd1;
        state_d = DECIDE;
      end
      DECIDE: if (accept) begin
        grant_d = win_oh;
        cnt_u_d = uni_q ? (is_exit ? cnt_u_q - CNT_W'(1) : cnt_u_q + CNT_W'(1)) : cnt_u_q;
        cnt_f_d = uni_q ? cnt_f_q : (is_exit ? cnt_f_q - CNT_W'(1) : cnt_f_q + CNT_W'(1));
        tmr_d = GW'(GATE_CYCLES - 1);
        state_d = OPEN;
      end else begin
        deny_d = win_oh;
        err_d = is_exit;
        state_d = WAIT_DROP;
      end
      OPEN: begin
        tmr_d = tmr_q - GW'(1);
        if (tmr_q == '0) state_d = req[win_q] ? WAIT_DROP : IDLE;
      end
      default: if (!req[win_q]) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      uni_q <= 1'b0;
      cnt_u_q <= '0;
      cnt_f_q <= '0;
      tmr_q <= '0;
      grant_q <= '0;
      deny_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      uni_q <= uni_d;
      cnt_u_q <= cnt_u_d;
      cnt_f_q <= cnt_f_d;
      tmr_q <= tmr_d;
      grant_q <= grant_d;
      deny_q <= deny_d;
      err_q <= err_d;
    end
  assign grant        = grant_q;
  assign deny         = deny_q;
  assign err          = err_q;
  assign gate_open    = state_q == OPEN ? win_oh : '0;
  assign car_parked_u = cnt_u_q;
  assign car_parked_f = cnt_f_q;
  assign busy         = state_q != IDLE;
endmodule
